uart_rx_controller: RTL and testbench

//  UART receiver, the far end of the TX controller's serial link. Oversamples uart_rxd,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick_gen.sv | 27 ++
 rtl/uart_rx_controller.sv | 199 +++++++++++++++++++
 tb/tb_uart_rx_controller.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, data width and baud divider helper.
package uart_pkg;

   localparam int unsigned DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   function automatic int unsigned baud_div(input int unsigned clk, input int unsigned baud,
                                            input int unsigned os);
      return clk / (baud * os);
   endfunction

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: counts DIV-1 down to 0 and emits a 1-cycle tick at 0.
module uart_baud_tick_gen #(
   parameter int unsigned DIV = 54
) (
   input  logic system_clock,
   input  logic cpu_rst_n,
   input  logic restart,
   output logic tick
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt_q;

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         cnt_q <= CW'(DIV - 1);
      end else if (restart || (cnt_q == '0)) begin
         cnt_q <= CW'(DIV - 1);
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tick = (cnt_q == '0);

endmodule

// File: rtl/uart_rx_controller.sv
// Oversampling UART receiver with byte pairing into 16-bit display words.
// Optional even parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_controller
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ  = 100_000_000,
   parameter int unsigned BAUD_RATE    = 115200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned IDLE_TO_BITS = 20
) (
   input  logic        system_clock,
   input  logic        cpu_rst_n,
   input  logic        uart_rxd,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_frame_err,
   output logic        rx_parity_err,
   output logic [15:0] display_value,
   output logic        display_update
);

   localparam int unsigned DIV = baud_div(CLK_FREQ_HZ, BAUD_RATE, OVERSAMPLE);
   localparam int unsigned SW  = $clog2(OVERSAMPLE);
   localparam int unsigned IW  = $clog2(IDLE_TO_BITS + 1);
   localparam logic [SW-1:0] MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] LAST = SW'(OVERSAMPLE - 1);

   rx_state_t state_q, state_d;

   logic          sync1_q, rxd_s, rxd_prev_q;
   logic          tick, restart, start_edge, sample_point, bit_boundary, timeout;
   logic [SW-1:0] sample_cnt_q;
   logic [2:0]    bit_cnt_q;
   logic [7:0]    shift_q, hi_q;
   logic [IW-1:0] idle_bits_q;
   logic          ptr_q;
   logic          data_smp, stop_smp, good_byte, frame_err, parity_fail, par_bad;

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         sync1_q    <= 1'b1;
         rxd_s      <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync1_q    <= uart_rxd;
         rxd_s      <= sync1_q;
         rxd_prev_q <= rxd_s;
      end
   end

   assign start_edge = rxd_prev_q & ~rxd_s;
   assign restart    = (state_q == IDLE) && start_edge;

   uart_baud_tick_gen #(
      .DIV (DIV)
   ) u_tick (
      .system_clock (system_clock),
      .cpu_rst_n    (cpu_rst_n),
      .restart      (restart),
      .tick         (tick)
   );

   // Mid-start sample re-phases the sample counter so later samples land mid-bit.
   always_comb begin
      sample_point = 1'b0;
      if (tick) begin
         unique case (state_q)
            START:                 sample_point = (sample_cnt_q == MID);
            DATA, PARITY, STOP:    sample_point = (sample_cnt_q == LAST);
            default:               sample_point = 1'b0;
         endcase
      end
   end

   assign bit_boundary = (state_q == IDLE) && tick && (sample_cnt_q == LAST);
   assign timeout      = (state_q == IDLE) &&
                         ((idle_bits_q == IW'(IDLE_TO_BITS)) ||
                          (bit_boundary && (idle_bits_q == IW'(IDLE_TO_BITS - 1))));

   // State register
   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (start_edge) state_d = START;
         START:     if (sample_point) state_d = rxd_s ? IDLE : DATA;
         DATA: begin
            if (sample_point && (bit_cnt_q == 3'(DATA_BITS - 1))) begin
`ifdef UART_RX_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
            end
         end
         PARITY:    if (sample_point) state_d = STOP;
         STOP:      if (sample_point) state_d = rxd_s ? IDLE : WAIT_IDLE;
         WAIT_IDLE: if (rxd_s) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Output/control decode
   always_comb begin
      data_smp    = 1'b0;
      stop_smp    = 1'b0;
      unique case (state_q)
         DATA:    data_smp = sample_point;
         STOP:    stop_smp = sample_point;
         default: ;
      endcase
      frame_err   = stop_smp & ~rxd_s;
      parity_fail = stop_smp & rxd_s & par_bad;
      good_byte   = stop_smp & rxd_s & ~par_bad;
   end

`ifdef UART_RX_PARITY_EN
   logic par_bit_q;
   logic parity_err_q;

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         par_bit_q    <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         if ((state_q == PARITY) && sample_point) par_bit_q <= rxd_s;
         parity_err_q <= parity_fail;
      end
   end

   assign par_bad       = ^{shift_q, par_bit_q};
   assign rx_parity_err = parity_err_q;
`else
   assign par_bad       = 1'b0;
   assign rx_parity_err = 1'b0;
`endif

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         sample_cnt_q <= '0;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         idle_bits_q  <= '0;
      end else begin
         if (restart) begin
            sample_cnt_q <= '0;
         end else if (tick) begin
            sample_cnt_q <= (sample_point || (sample_cnt_q == LAST)) ? '0 : sample_cnt_q + 1'b1;
         end

         if (state_q == START) begin
            bit_cnt_q <= '0;
         end else if (data_smp) begin
            bit_cnt_q <= bit_cnt_q + 1'b1;
         end

         if (data_smp) shift_q <= {rxd_s, shift_q[7:1]};

         if ((state_q != IDLE) || restart) begin
            idle_bits_q <= '0;
         end else if (bit_boundary && (idle_bits_q != IW'(IDLE_TO_BITS))) begin
            idle_bits_q <= idle_bits_q + 1'b1;
         end
      end
   end

   always_ff @(posedge system_clock or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         rx_data        <= '0;
         rx_valid       <= 1'b0;
         rx_frame_err   <= 1'b0;
         display_value  <= '0;
         display_update <= 1'b0;
         hi_q           <= '0;
         ptr_q          <= 1'b0;
      end else begin
         rx_valid       <= good_byte;
         rx_frame_err   <= frame_err;
         display_update <= good_byte & ptr_q;
         if (frame_err || parity_fail || timeout) begin
            ptr_q <= 1'b0;
         end else if (good_byte) begin
            rx_data <= shift_q;
            ptr_q   <= ~ptr_q;
            if (!ptr_q) hi_q <= shift_q;
            else        display_value <= {hi_q, shift_q};
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: serial frames driven at the line bit rate.
module tb_uart_rx_controller;

   localparam int unsigned CLK_HZ = 800_000;
   localparam int unsigned BAUD   = 12_500;
   localparam int unsigned OS     = 16;
   localparam int unsigned ITB    = 20;
   localparam int          BIT    = 64;   // clocks per bit: DIV = 4, 16 ticks

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rxd = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_frame_err, rx_parity_err, display_update;
   logic [15:0] display_value;

   int n_cmp = 0;
   int n_fail = 0;

   int n_valid = 0, n_ferr = 0, n_perr = 0, n_upd = 0;
   int n_wide = 0, n_misalign = 0, n_abcd = 0;
   logic p_valid = 1'b0, p_ferr = 1'b0, p_perr = 1'b0, p_upd = 1'b0;

   always #5 clk = ~clk;

   uart_rx_controller #(
      .CLK_FREQ_HZ  (CLK_HZ),
      .BAUD_RATE    (BAUD),
      .OVERSAMPLE   (OS),
      .IDLE_TO_BITS (ITB)
   ) dut (
      .system_clock   (clk),
      .cpu_rst_n      (rst_n),
      .uart_rxd       (rxd),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .rx_frame_err   (rx_frame_err),
      .rx_parity_err  (rx_parity_err),
      .display_value  (display_value),
      .display_update (display_update)
   );

   always @(negedge clk) begin
      if (rx_valid) n_valid <= n_valid + 1;
      if (rx_frame_err) n_ferr <= n_ferr + 1;
      if (rx_parity_err) n_perr <= n_perr + 1;
      if (display_update) n_upd <= n_upd + 1;
      if ((rx_valid && p_valid) || (rx_frame_err && p_ferr) || (rx_parity_err && p_perr) ||
          (display_update && p_upd))
         n_wide <= n_wide + 1;
      if (display_update && !rx_valid) n_misalign <= n_misalign + 1;
      if (display_value == 16'hABCD) n_abcd <= n_abcd + 1;
      p_valid <= rx_valid;
      p_ferr  <= rx_frame_err;
      p_perr  <= rx_parity_err;
      p_upd   <= display_update;
   end

   task automatic bits(input int n);
      repeat (n * BIT) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] d, input logic stop);
      rxd = 1'b0;
      bits(1);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         bits(1);
      end
`ifdef UART_RX_PARITY_EN
      rxd = ^d;
      bits(1);
`endif
      rxd = stop;
      bits(1);
      rxd = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk);
      if (rx_data !== 8'h00) begin
         $display("FAIL reset_rx_data got %h want 00", rx_data); n_fail++;
      end
      n_cmp++;
      if ({rx_valid, rx_frame_err, rx_parity_err, display_update} !== 4'b0000) begin
         $display("FAIL reset_strobes got %b want 0000",
                  {rx_valid, rx_frame_err, rx_parity_err, display_update}); n_fail++;
      end
      n_cmp++;
      if (display_value !== 16'h0000) begin
         $display("FAIL reset_display got %h want 0000", display_value); n_fail++;
      end
      n_cmp++;
      #1 rst_n = 1'b1;
      bits(2);
   endtask

   task automatic test_single();
      int v0 = n_valid, f0 = n_ferr, p0 = n_perr, u0 = n_upd;
      send_byte(8'hA5, 1'b1);
      bits(1);
      if (n_valid - v0 !== 1) begin
         $display("FAIL single_valid_count got %0d want 1", n_valid - v0); n_fail++;
      end
      n_cmp++;
      if (rx_data !== 8'hA5) begin
         $display("FAIL single_data got %h want a5", rx_data); n_fail++;
      end
      n_cmp++;
      if (n_upd - u0 !== 0) begin
         $display("FAIL single_no_update got %0d want 0", n_upd - u0); n_fail++;
      end
      n_cmp++;
      if ((n_ferr - f0) + (n_perr - p0) !== 0) begin
         $display("FAIL single_no_err got %0d want 0", (n_ferr - f0) + (n_perr - p0)); n_fail++;
      end
      n_cmp++;
      bits(24);   // idle timeout drops the held 0xA5
   endtask

   task automatic test_back_to_back();
      int v0 = n_valid, u0 = n_upd;
      send_byte(8'h30, 1'b1);
      send_byte(8'h39, 1'b1);
      bits(1);
      if (n_valid - v0 !== 2) begin
         $display("FAIL b2b_valid_count got %0d want 2", n_valid - v0); n_fail++;
      end
      n_cmp++;
      if (display_value !== 16'h3039) begin
         $display("FAIL b2b_display got %h want 3039", display_value); n_fail++;
      end
      n_cmp++;
      if (n_upd - u0 !== 1) begin
         $display("FAIL b2b_update_count got %0d want 1", n_upd - u0); n_fail++;
      end
      n_cmp++;
      if (n_misalign !== 0) begin
         $display("FAIL b2b_update_align got %0d want 0", n_misalign); n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_frame_err();
      int v0 = n_valid, f0 = n_ferr;
      send_byte(8'h55, 1'b0);
      rxd = 1'b0;
      bits(2);
      if (n_ferr - f0 !== 1) begin
         $display("FAIL ferr_count got %0d want 1", n_ferr - f0); n_fail++;
      end
      n_cmp++;
      if (n_valid - v0 !== 0) begin
         $display("FAIL ferr_no_valid got %0d want 0", n_valid - v0); n_fail++;
      end
      n_cmp++;
      rxd = 1'b1;
      bits(1);
      send_byte(8'h12, 1'b1);
      send_byte(8'h34, 1'b1);
      bits(1);
      if (display_value !== 16'h1234) begin
         $display("FAIL ferr_recover_display got %h want 1234", display_value); n_fail++;
      end
      n_cmp++;
      if (n_ferr - f0 !== 1) begin
         $display("FAIL ferr_single_in_wait got %0d want 1", n_ferr - f0); n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_glitch();
      int v0 = n_valid, f0 = n_ferr;
      rxd = 1'b0;
      repeat (12) @(posedge clk);
      #1 rxd = 1'b1;
      bits(2);
      send_byte(8'h7E, 1'b1);
      bits(1);
      if (n_valid - v0 !== 1) begin
         $display("FAIL glitch_valid_count got %0d want 1", n_valid - v0); n_fail++;
      end
      n_cmp++;
      if (rx_data !== 8'h7E) begin
         $display("FAIL glitch_data got %h want 7e", rx_data); n_fail++;
      end
      n_cmp++;
      if (n_ferr - f0 !== 0) begin
         $display("FAIL glitch_no_ferr got %0d want 0", n_ferr - f0); n_fail++;
      end
      n_cmp++;
      bits(24);
   endtask

   task automatic test_idle_timeout();
      int u0 = n_upd;
      send_byte(8'hAB, 1'b1);
      bits(25);
      send_byte(8'hCD, 1'b1);
      send_byte(8'hEF, 1'b1);
      bits(1);
      if (display_value !== 16'hCDEF) begin
         $display("FAIL timeout_display got %h want cdef", display_value); n_fail++;
      end
      n_cmp++;
      if (n_abcd !== 0) begin
         $display("FAIL timeout_never_abcd got %0d want 0", n_abcd); n_fail++;
      end
      n_cmp++;
      if (n_upd - u0 !== 1) begin
         $display("FAIL timeout_update_count got %0d want 1", n_upd - u0); n_fail++;
      end
      n_cmp++;
   endtask

   task automatic test_reset_mid_frame();
      int v0, s0;
      logic [7:0] d = 8'h5A;
      send_byte(8'h11, 1'b1);
      v0 = n_valid;
      s0 = n_ferr + n_perr + n_upd;
      rxd = 1'b0;
      bits(1);
      for (int i = 0; i < 3; i++) begin
         rxd = d[i];
         bits(1);
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      if (display_value !== 16'h0000) begin
         $display("FAIL midrst_display got %h want 0000", display_value); n_fail++;
      end
      n_cmp++;
      if ({rx_data, rx_valid, rx_frame_err, rx_parity_err, display_update} !== 12'h000) begin
         $display("FAIL midrst_outputs got %h want 000",
                  {rx_data, rx_valid, rx_frame_err, rx_parity_err, display_update}); n_fail++;
      end
      n_cmp++;
      rxd = 1'b1;
      #1 rst_n = 1'b1;
      bits(2);
      if ((n_valid - v0) + (n_ferr + n_perr + n_upd - s0) !== 0) begin
         $display("FAIL midrst_no_strobes got %0d want 0",
                  (n_valid - v0) + (n_ferr + n_perr + n_upd - s0)); n_fail++;
      end
      n_cmp++;
      send_byte(8'h01, 1'b1);
      send_byte(8'h02, 1'b1);
      bits(1);
      if (display_value !== 16'h0102) begin
         $display("FAIL midrst_recover_display got %h want 0102", display_value); n_fail++;
      end
      n_cmp++;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0 = n_valid, p0 = n_perr, f0 = n_ferr;
      logic [7:0] d = 8'h03;
      rxd = 1'b0;
      bits(1);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         bits(1);
      end
      rxd = ~(^d);
      bits(1);
      rxd = 1'b1;
      bits(2);
      if (n_perr - p0 !== 1) begin
         $display("FAIL parity_err_count got %0d want 1", n_perr - p0); n_fail++;
      end
      n_cmp++;
      if ((n_valid - v0) + (n_ferr - f0) !== 0) begin
         $display("FAIL parity_no_valid got %0d want 0", (n_valid - v0) + (n_ferr - f0));
         n_fail++;
      end
      n_cmp++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_idle_timeout();
      test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      if (n_wide !== 0) begin
         $display("FAIL strobe_width got %0d wide strobes want 0", n_wide); n_fail++;
      end
      n_cmp++;
      if (rx_parity_err !== 1'b0) begin
         $display("FAIL parity_idle got %b want 0", rx_parity_err); n_fail++;
      end
      n_cmp++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
